// File: rtl/mercury_pkg.sv
// Shared front-end types and sizing for the IFU and decode.
package mercury_pkg;

    // One fetched instruction parcel as it travels from fetch to decode.
    typedef struct packed {
        logic [15:0] instr;
        logic [13:0] pc_lo;
        logic        pred_taken;
        logic        fault;
    } fetch_entry_t;

    // Fetch queue geometry, shared so the IFU and decode agree.
    localparam int IFU_FQ_DEPTH  = 8;
    localparam int IFU_DEQ_WIDTH = 2;

endpackage

// File: rtl/ifu_fq_ptr_ctrl.sv
// Pointer and occupancy control for the fetch queue: read/write pointers,
// entry count, flush/reset handling and the status flags derived from count.
module ifu_fq_ptr_ctrl
    import mercury_pkg::*;
#(
    parameter int  DEPTH        = IFU_FQ_DEPTH,
    parameter int  DEQ_WIDTH    = IFU_DEQ_WIDTH,
    parameter int  AFULL_THRESH = DEPTH - 2,
    localparam int AW           = $clog2(DEPTH),
    localparam int CW           = $clog2(DEPTH + 1),
    localparam int NW           = $clog2(DEQ_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          enq_fire,
    input  logic [NW-1:0] n,
    output logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] wr_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    // Pointer/count update; flush wins over any enqueue or dequeue this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap mod DEPTH by truncation since DEPTH is a power of 2.
            rd_ptr <= rd_ptr + AW'(n);
            wr_ptr <= wr_ptr + AW'(enq_fire);
            count  <= count + CW'(enq_fire) - CW'(n);
        end
    end

    // Status flags come from the registered count only.
    always_comb begin
        full        = (count == DEPTH_C);
        empty       = (count == '0);
        almost_full = (count >= AFULL_C);
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Multi-read fetch queue between fetch and decode. Holds the storage array,
// write decode and the DEQ_WIDTH read muxes; pointer state lives in
// ifu_fq_ptr_ctrl.
//
// Handshakes: an entry is enqueued on a rising edge where enq_valid and
// enq_ready are both high; enq_ready depends only on registered occupancy.
// On the dequeue side deq_valid is a thermometer of available entries and
// decode reports how many it takes via deq_num, which is saturated to count.
module ifu_fetch_queue
    import mercury_pkg::*;
#(
    parameter int  DATA_WIDTH   = $bits(fetch_entry_t),
    parameter int  DEPTH        = IFU_FQ_DEPTH,
    parameter int  DEQ_WIDTH    = IFU_DEQ_WIDTH,
    parameter int  AFULL_THRESH = DEPTH - 2,
    localparam int AW           = $clog2(DEPTH),
    localparam int CW           = $clog2(DEPTH + 1),
    localparam int NW           = $clog2(DEQ_WIDTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [DATA_WIDTH-1:0]         enq_data,
    output logic [DEQ_WIDTH-1:0]          deq_valid,
    output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data,
    input  logic [NW-1:0]                 deq_num,
    output logic [CW-1:0]                 count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full
);

    localparam int MW = (CW > NW) ? CW : NW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic                  enq_fire;
    logic [NW-1:0]         n;

    ifu_fq_ptr_ctrl #(
        .DEPTH        (DEPTH),
        .DEQ_WIDTH    (DEQ_WIDTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .enq_fire    (enq_fire),
        .n           (n),
        .rd_ptr      (rd_ptr),
        .wr_ptr      (wr_ptr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    // Accept decision and pop amount; an over-ask from decode is clipped to count.
    always_comb begin
        enq_ready = !full;
        enq_fire  = enq_valid && !full;
        if (MW'(deq_num) > MW'(count)) begin
            n = NW'(count);
        end else begin
            n = deq_num;
        end
    end

    // Storage write; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    // Read muxes: slot i presents the entry at rd_ptr+i, oldest in slot 0.
    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            deq_valid[i]                        = (count > CW'(i));
            deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule
